// File: rtl/mole_spawner.sv
// Mole scheduler for the whack-a-mole game: draws gap lengths and hole positions
// from the random stream, judges clicks against the mole box and keeps score/misses.
module mole_spawner #(
  parameter int unsigned X0         = 112,
  parameter int unsigned Y0         = 184,
  parameter int unsigned X_STEP     = 200,
  parameter int unsigned Y_STEP     = 200,
  parameter int unsigned MOLE_W     = 96,
  parameter int unsigned MOLE_H     = 96,
  parameter int unsigned UP_CYCLES  = 65_000_000,
  parameter int unsigned HIT_CYCLES = 16_250_000,
  parameter int unsigned WAIT_BASE  = 32_500_000,
  parameter int unsigned WAIT_UNIT  = 65_000,
  parameter int unsigned MAX_MISS   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  random_number,
  input  logic        start,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  output logic        mole_visible,
  output logic        mole_hit,
  output logic [10:0] mole_xpos,
  output logic [10:0] mole_ypos,
  output logic [7:0]  score,
  output logic [1:0]  misses,
  output logic        game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_UP,
    S_HIT,
    S_OVER
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  score_q, score_d;
  logic [1:0]  misses_q, misses_d;
  logic [2:0]  prev_q, prev_d;
  logic [10:0] xpos_q, xpos_d;
  logic [10:0] ypos_q, ypos_d;
  logic        visible_q, hit_q, over_q;

  logic [31:0] gap_load;
  logic [2:0]  idx;
  logic [11:0] x_lo, x_hi, y_lo, y_hi;
  logic        click_hit;
  logic [1:0]  misses_inc;

  assign gap_load   = 32'(WAIT_BASE) + 32'(random_number) * 32'(WAIT_UNIT);
  // Never reuse the previous hole: bump to the next one (wraps 7 -> 0).
  assign idx        = (random_number[2:0] == prev_q) ? random_number[2:0] + 3'd1
                                                     : random_number[2:0];
  assign x_lo       = {1'b0, xpos_q};
  assign x_hi       = x_lo + 12'(MOLE_W);
  assign y_lo       = {1'b0, ypos_q};
  assign y_hi       = y_lo + 12'(MOLE_H);
  assign click_hit  = mouse_left && (mouse_xpos >= x_lo) && (mouse_xpos < x_hi)
                                 && (mouse_ypos >= y_lo) && (mouse_ypos < y_hi);
  assign misses_inc = misses_q + 2'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    score_d  = score_q;
    misses_d = misses_q;
    prev_d   = prev_q;
    xpos_d   = xpos_q;
    ypos_d   = ypos_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d  = S_GAP;
          score_d  = '0;
          misses_d = '0;
          cnt_d    = gap_load;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_UP;
          prev_d  = idx;
          xpos_d  = 11'(X0 + X_STEP * 32'(idx[1:0]));
          ypos_d  = 11'(Y0 + Y_STEP * 32'(idx[2]));
          cnt_d   = UP_CYCLES - 1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_UP: begin
        // A hit takes precedence over the timeout on the final cycle.
        if (click_hit) begin
          state_d = S_HIT;
          score_d = (score_q == '1) ? score_q : score_q + 8'd1;
          cnt_d   = HIT_CYCLES - 1;
        end else if (cnt_q == '0) begin
          misses_d = misses_inc;
          if (32'(misses_inc) == MAX_MISS) begin
            state_d = S_OVER;
          end else begin
            state_d = S_GAP;
            cnt_d   = gap_load;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_HIT: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = gap_load;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      score_q   <= '0;
      misses_q  <= '0;
      prev_q    <= '0;
      xpos_q    <= '0;
      ypos_q    <= '0;
      visible_q <= 1'b0;
      hit_q     <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      score_q   <= score_d;
      misses_q  <= misses_d;
      prev_q    <= prev_d;
      xpos_q    <= xpos_d;
      ypos_q    <= ypos_d;
      visible_q <= (state_d == S_UP) || (state_d == S_HIT);
      hit_q     <= (state_d == S_HIT);
      over_q    <= (state_d == S_OVER);
    end
  end

  assign mole_visible = visible_q;
  assign mole_hit     = hit_q;
  assign mole_xpos    = xpos_q;
  assign mole_ypos    = ypos_q;
  assign score        = score_q;
  assign misses       = misses_q;
  assign game_over    = over_q;

endmodule
